// File: rtl/clk_pkg.sv
// Shared definitions for the real-time clock time-set logic: display field
// encodings, field limits, the edit-session state encoding and the modulo
// step / capture clamp helpers used on the shadow time registers.
package clk_pkg;

  // Field currently being edited, drives the display blink
  localparam logic [1:0] EF_NONE  = 2'd0;
  localparam logic [1:0] EF_HOURS = 2'd1;
  localparam logic [1:0] EF_MIN   = 2'd2;
  localparam logic [1:0] EF_SEC   = 2'd3;

  // Largest legal value of each field
  localparam logic [5:0] HOURS_MAX  = 6'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  // Edit-session states
  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    COMMIT = 3'd4
  } state_e;

  // One modulo step up or down inside 0..max_val
  function automatic logic [5:0] step_wrap(input logic [5:0] value,
                                           input logic [5:0] max_val,
                                           input logic       up);
    if (up) begin
      return (value >= max_val) ? 6'd0 : value + 6'd1;
    end
    return (value == 6'd0) ? max_val : value - 6'd1;
  endfunction

  // Out-of-range live values are replaced by 0 when captured for editing
  function automatic logic [5:0] clamp_field(input logic [5:0] value,
                                             input logic [5:0] max_val);
    return (value > max_val) ? 6'd0 : value;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Edge detect plus hold-to-repeat for one debounced button. Emits a one-cycle
// step on the press, a second step REPEAT_DELAY cycles later, then one step
// every REPEAT_RATE cycles while the button stays held. While the opposing
// button is also high no step is produced and the repeat timing restarts.
module btn_repeat #(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int CNT_W        = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic inhibit,
  output logic press,
  output logic step
);

  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             prev_q;
  logic             repeating_q;
  logic [CNT_W-1:0] cnt_q;
  logic             held;
  logic             rep_hit;

  // cnt_q counts cycles since the last step; the target switches from the
  // initial delay to the repeat rate once the first repeat has fired
  assign press   = btn & ~prev_q;
  assign held    = btn & prev_q & ~inhibit;
  assign rep_hit = held & (cnt_q == (repeating_q ? RATE_C : DELAY_C));
  assign step    = ~inhibit & (press | rep_hit);

  // Button history and repeat timing
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      prev_q      <= 1'b0;
      repeating_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      prev_q <= btn;
      if (!btn || inhibit) begin
        repeating_q <= 1'b0;
        cnt_q       <= '0;
      end else if (press) begin
        repeating_q <= 1'b0;
        cnt_q       <= CNT_ONE;
      end else if (rep_hit) begin
        repeating_q <= 1'b1;
        cnt_q       <= CNT_ONE;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/clk_set_ctrl.sv
// Time-set controller for the real-time clock counter. A mode press freezes
// the counter and snapshots the live time into shadow registers; inc/dec step
// the active field with wrap-around; leaving the seconds field (or idling too
// long) commits the shadow time with a one-cycle load strobe.
module clk_set_ctrl
  import clk_pkg::*;
#(
  parameter int REPEAT_DELAY   = 50_000_000,
  parameter int REPEAT_RATE    = 10_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000,
  parameter int CNT_W          = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] cur_seconds,
  input  logic [5:0] cur_minutes,
  input  logic [4:0] cur_hours,
  output logic       run_en,
  output logic       load,
  output logic [5:0] load_seconds,
  output logic [5:0] load_minutes,
  output logic [4:0] load_hours,
  output logic [1:0] edit_field
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e           state_q, state_d;
  logic             mode_prev_q;
  logic             mode_press;
  logic             inc_press, inc_step;
  logic             dec_press, dec_step;
  logic             activity;
  logic             in_set;
  logic             timeout_hit;
  logic             field_step;
  logic [CNT_W-1:0] timeout_q;

  logic [4:0]       shadow_hours_q;
  logic [5:0]       shadow_minutes_q;
  logic [5:0]       shadow_seconds_q;
  logic [5:0]       hours_wrap, minutes_wrap, seconds_wrap;
  logic [5:0]       hours_cap, minutes_cap, seconds_cap;

  logic             run_en_d, load_d;
  logic [4:0]       load_hours_d;
  logic [5:0]       load_minutes_d, load_seconds_d;
  logic [1:0]       edit_field_d;

  // Mode only needs an edge; inc and dec also auto-repeat
  assign mode_press = btn_mode & ~mode_prev_q;

  btn_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE),
    .CNT_W        (CNT_W)
  ) u_inc (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn_inc),
    .inhibit (btn_dec),
    .press   (inc_press),
    .step    (inc_step)
  );

  btn_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE),
    .CNT_W        (CNT_W)
  ) u_dec (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn_dec),
    .inhibit (btn_inc),
    .press   (dec_press),
    .step    (dec_step)
  );

  assign activity = mode_press | inc_press | dec_press | inc_step | dec_step;
  assign in_set   = (state_q == SET_H) || (state_q == SET_M) || (state_q == SET_S);

  // Timeout only fires on a quiet cycle, so the shadow never changes on the
  // same edge that commits it
  assign timeout_hit = in_set & ~activity & (timeout_q == TIMEOUT_LAST);

  // Mode has priority: a step arriving together with a mode press is dropped
  assign field_step = in_set & ~mode_press & (inc_step | dec_step);

  assign hours_wrap   = step_wrap({1'b0, shadow_hours_q}, HOURS_MAX, inc_step);
  assign minutes_wrap = step_wrap(shadow_minutes_q, MINSEC_MAX, inc_step);
  assign seconds_wrap = step_wrap(shadow_seconds_q, MINSEC_MAX, inc_step);

  assign hours_cap    = clamp_field({1'b0, cur_hours}, HOURS_MAX);
  assign minutes_cap  = clamp_field(cur_minutes, MINSEC_MAX);
  assign seconds_cap  = clamp_field(cur_seconds, MINSEC_MAX);

  // State register and mode button history
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      mode_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= btn_mode;
    end
  end

  // Next-state logic for the edit session
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      RUN:     if (mode_press) state_d = SET_H;
      SET_H:   if (mode_press) state_d = SET_M;
               else if (timeout_hit) state_d = COMMIT;
      SET_M:   if (mode_press) state_d = SET_S;
               else if (timeout_hit) state_d = COMMIT;
      SET_S:   if (mode_press || timeout_hit) state_d = COMMIT;
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Shadow time: snapshot on entry, then modulo steps on the active field
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_hours_q   <= '0;
      shadow_minutes_q <= '0;
      shadow_seconds_q <= '0;
    end else if (state_q == RUN && mode_press) begin
      shadow_hours_q   <= hours_cap[4:0];
      shadow_minutes_q <= minutes_cap;
      shadow_seconds_q <= seconds_cap;
    end else if (field_step) begin
      case (state_q)
        SET_H:   shadow_hours_q   <= hours_wrap[4:0];
        SET_M:   shadow_minutes_q <= minutes_wrap;
        SET_S:   shadow_seconds_q <= seconds_wrap;
        default: ;
      endcase
    end
  end

  // Idle timer: restarts on any button activity or state change
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= '0;
    end else if (!in_set || activity || (state_d != state_q)) begin
      timeout_q <= '0;
    end else begin
      timeout_q <= timeout_q + CNT_ONE;
    end
  end

  // Output values for the state being entered, so the registered outputs
  // line up with the state register
  always_comb begin
    run_en_d       = 1'b1;
    load_d         = 1'b0;
    load_hours_d   = load_hours;
    load_minutes_d = load_minutes;
    load_seconds_d = load_seconds;
    edit_field_d   = EF_NONE;
    unique case (state_d)
      RUN: ;
      SET_H: begin
        run_en_d     = 1'b0;
        edit_field_d = EF_HOURS;
      end
      SET_M: begin
        run_en_d     = 1'b0;
        edit_field_d = EF_MIN;
      end
      SET_S: begin
        run_en_d     = 1'b0;
        edit_field_d = EF_SEC;
      end
      COMMIT: begin
        load_d         = 1'b1;
        load_hours_d   = shadow_hours_q;
        load_minutes_d = shadow_minutes_q;
        load_seconds_d = shadow_seconds_q;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      run_en       <= 1'b1;
      load         <= 1'b0;
      load_hours   <= '0;
      load_minutes <= '0;
      load_seconds <= '0;
      edit_field   <= EF_NONE;
    end else begin
      run_en       <= run_en_d;
      load         <= load_d;
      load_hours   <= load_hours_d;
      load_minutes <= load_minutes_d;
      load_seconds <= load_seconds_d;
      edit_field   <= edit_field_d;
    end
  end

endmodule
